wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback merge stage directly upstream of the register file's single write port. It combines the in-order pipeline writeback with results from a long-latency unit (load/multiply-divide) that uses a valid/ready handshake, and buffers deferred results in a small FIFO. It also keeps a per-register busy scoreboard that the hazard logic uses to stall ID/EX reads of registers still owed a long-latency result.

Parameters:
XLEN, 32, data width of writeback values
FIFO_DEPTH, 4, long-latency result buffer entries; power of 2, >= 2

Ports:
clk  input  1  clock
rst  input  1  reset
pipe_we  input  1  pipeline writeback valid; no backpressure
pipe_rd  input  5  pipeline destination register
pipe_wdata  input  XLEN  pipeline result
lu_valid  input  1  long-latency result valid
lu_ready  output  1  long-latency result accepted
lu_rd  input  5  long-latency destination register
lu_wdata  input  XLEN  long-latency result
alloc_valid  input  1  long-latency op issued this cycle
alloc_rd  input  5  its destination register
rf_we  output  1  register file write enable
rf_waddr  output  5  register file write address
rf_wdata  output  XLEN  register file write data
busy  output  32  per-register pending long-latency result
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears rf_we, rf_waddr, rf_wdata, busy, fifo_count, and the FIFO pointers. lu_ready=1 after reset. A reset mid-operation discards all buffered results.
- lu_ready = (fifo_count < FIFO_DEPTH). It is a function of registered state only and does not depend on a same-cycle pop.
- Accept: lu_valid && lu_ready. If lu_rd==0, the result is accepted and discarded (no enqueue). Otherwise it is enqueued at the clock edge.
- Pipe writes with pipe_rd==0 are ignored.
- Selection each cycle, registered into rf_* at the edge (1-cycle latency):
  1. pipe_we && pipe_rd!=0 -> pipe result. The FIFO does not pop.
  2. Otherwise, if the FIFO is non-empty -> FIFO head, which pops.
  3. Otherwise -> rf_we=0. rf_waddr/rf_wdata hold their previous values.
- Timing: the pipe result appears on rf_* in cycle N+1. A FIFO result accepted in cycle N is visible as the head in N+1, so the earliest rf_we for it is N+2.
- Simultaneous enqueue and pop are allowed when full: count stays at FIFO_DEPTH. However, lu_ready was 0, so no enqueue occurs when full.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is in the range 0..FIFO_DEPTH.
- Ordering: FIFO results are written in acceptance order. A continuous pipe stream starves the FIFO; that is acceptable by design.
- Scoreboard:
  - alloc_valid && alloc_rd!=0 sets busy[alloc_rd] at the edge.
  - The bit clears at the edge ending a cycle in which rf_we=1 with a long-latency source for that address, i.e. after the register file has been written.
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - busy[0] is always 0.
  - Pipe writes never clear busy bits.
  - The hazard unit guarantees no second alloc to a busy register. If one occurs anyway, the bit clears on the first completion.

Optional Feature:
Macro WB_ARB_BYPASS_EN.
- Defined: in a cycle with no valid pipe write and an empty FIFO, an accepted lu result with lu_rd!=0 goes straight into the rf_* registers. It is not enqueued, and rf_we rises in N+1.
- Undefined: every long-latency result passes through the FIFO, giving a minimum latency of 2 cycles.
- Scoreboard clear rules are unchanged in both cases.

Test Plan:
- Reset: assert rst mid-stream with 3 entries buffered -> immediately rf_we=0, busy=0, fifo_count=0, lu_ready=1. After release, no stale write occurs.
- Pipe write, single cycle: pipe_we=1, rd=5, data=0xDEADBEEF in cycle N -> cycle N+1 shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Cycle N+2 shows rf_we=0.
- Long-latency result: alloc rd=7, then lu_valid rd=7, data=0x12345678 in cycle N with the pipe idle -> rf_we in N+2 (N+1 when bypass is enabled). busy[7] is 1 until the edge after that write, then 0.
- Contention: the pipe writes every cycle for 6 cycles while 4 lu results arrive -> the FIFO fills to 4 and lu_ready drops to 0. The 5th lu_valid stalls. After the pipe stops, the 4 results drain in order on consecutive cycles.
- x0 handling: pipe_rd=0 and lu_rd=0 with alloc_rd=0 -> no rf_we, no enqueue (fifo_count unchanged), lu_ready handshake completes, busy[0]=0.
- Same-cycle set/clear: the rd=9 result is written in the same cycle as a new alloc rd=9 -> busy[9] remains 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback merge bus: pipeline/long-latency result sources in, register file write port and scoreboard out.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface wb_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          pipe_we;
  logic [4:0]                    pipe_rd;
  logic [XLEN-1:0]               pipe_wdata;
  logic                          lu_valid;
  logic                          lu_ready;
  logic [4:0]                    lu_rd;
  logic [XLEN-1:0]               lu_wdata;
  logic                          alloc_valid;
  logic [4:0]                    alloc_rd;
  logic                          rf_we;
  logic [4:0]                    rf_waddr;
  logic [XLEN-1:0]               rf_wdata;
  logic [31:0]                   busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata,
    input  lu_valid, lu_rd, lu_wdata,
    input  alloc_valid, alloc_rd,
    output lu_ready, rf_we, rf_waddr, rf_wdata, busy, fifo_count
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wdata,
    output lu_valid, lu_rd, lu_wdata,
    output alloc_valid, alloc_rd,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, busy, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback merge of pipeline and long-latency results into one register file write port, with busy scoreboard.
// Optional macro WB_ARB_BYPASS_EN lets a long-latency result skip an empty FIFO when the pipe is idle.
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            rf_lu_q;   // rf_* currently holds a long-latency result
  logic [31:0]     busy_q;

  logic pipe_hit, lu_ready_c, accept, fifo_empty, bypass, push, pop;
  logic [31:0] set_mask, clr_mask, busy_next;

  assign pipe_hit   = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign lu_ready_c = (count < DEPTH_C);
  assign accept     = bus.lu_valid && lu_ready_c;
  assign fifo_empty = (count == '0);

`ifdef WB_ARB_BYPASS_EN
  assign bypass = accept && (bus.lu_rd != 5'd0) && !pipe_hit && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // x0 results complete the handshake but are dropped here
  assign push = accept && (bus.lu_rd != 5'd0) && !bypass;
  assign pop  = !pipe_hit && !fifo_empty;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.alloc_valid && (bus.alloc_rd != 5'd0))
      set_mask[bus.alloc_rd] = 1'b1;
    if (rf_we_q && rf_lu_q)
      clr_mask[rf_waddr_q] = 1'b1;
    busy_next = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  // result buffer storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.lu_wdata;
      fifo_rd[wr_ptr]   <= bus.lu_rd;
    end
  end

  // pointers, occupancy, register-file port and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_lu_q    <= 1'b0;
      busy_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count + CW'(push) - CW'(pop);
      busy_q <= busy_next;
      if (pipe_hit) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.pipe_rd;
        rf_wdata_q <= bus.pipe_wdata;
        rf_lu_q    <= 1'b0;
      end else if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= fifo_rd[rd_ptr];
        rf_wdata_q <= fifo_data[rd_ptr];
        rf_lu_q    <= 1'b1;
      end else if (bypass) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.lu_rd;
        rf_wdata_q <= bus.lu_wdata;
        rf_lu_q    <= 1'b1;
      end else begin
        rf_we_q    <= 1'b0;
        rf_lu_q    <= 1'b0;
      end
    end
  end

  assign bus.lu_ready   = lu_ready_c;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle vector table plus long-latency and mid-stream reset sequences.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

  wb_arbiter #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        av;
    logic [4:0]  ard;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [2:0]  ecnt;
    logic        erdy;
    logic [31:0] ebusy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input int pwe, input int prd, input int pdat,
                              input int lv, input int lrd, input int ldat,
                              input int av, input int ard,
                              input int ewe, input int ewa, input int ewd,
                              input int ecnt, input int erdy, input int ebusy);
    vec_t r;
    r.pwe = (pwe != 0);  r.prd = 5'(prd);  r.pdat = 32'(pdat);
    r.lv  = (lv != 0);   r.lrd = 5'(lrd);  r.ldat = 32'(ldat);
    r.av  = (av != 0);   r.ard = 5'(ard);
    r.ewe = (ewe != 0);  r.ewa = 5'(ewa);  r.ewd = 32'(ewd);
    r.ecnt = 3'(ecnt);   r.erdy = (erdy != 0); r.ebusy = 32'(ebusy);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pipe_we = 1'b0; bus.pipe_rd = '0; bus.pipe_wdata = '0;
    bus.lu_valid = 1'b0; bus.lu_rd = '0; bus.lu_wdata = '0;
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0;
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    bus.pipe_we = t.pwe;  bus.pipe_rd = t.prd;  bus.pipe_wdata = t.pdat;
    bus.lu_valid = t.lv;  bus.lu_rd = t.lrd;    bus.lu_wdata = t.ldat;
    bus.alloc_valid = t.av; bus.alloc_rd = t.ard;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_rf_we", idx),      32'(bus.rf_we),      32'(t.ewe));
    chk($sformatf("v%0d_rf_waddr", idx),   32'(bus.rf_waddr),   32'(t.ewa));
    chk($sformatf("v%0d_rf_wdata", idx),   bus.rf_wdata,        t.ewd);
    chk($sformatf("v%0d_fifo_count", idx), 32'(bus.fifo_count), 32'(t.ecnt));
    chk($sformatf("v%0d_lu_ready", idx),   32'(bus.lu_ready),   32'(t.erdy));
    chk($sformatf("v%0d_busy", idx),       bus.busy,            t.ebusy);
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    // Columns: pipe we/rd/data, lu valid/rd/data, alloc valid/rd -> rf we/addr/data, count, ready, busy
    vt.push_back(mk(1,  5, 32'hDEADBEEF, 0,  0, 0,       0,  0, 1,  5, 32'hDEADBEEF, 0, 1, 32'h0));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 0,  5, 32'hDEADBEEF, 0, 1, 32'h0));
    vt.push_back(mk(1,  0, 32'h1111,     1,  0, 32'h2222, 1, 0, 0,  5, 32'hDEADBEEF, 0, 1, 32'h0));
    vt.push_back(mk(1, 20, 32'hA0,       0,  0, 0,       1, 10, 1, 20, 32'hA0,       0, 1, 32'h0400));
    vt.push_back(mk(1, 21, 32'hA1,       1, 10, 32'h10,  1, 11, 1, 21, 32'hA1,       1, 1, 32'h0C00));
    vt.push_back(mk(1, 22, 32'hA2,       1, 11, 32'h11,  1, 12, 1, 22, 32'hA2,       2, 1, 32'h1C00));
    vt.push_back(mk(1, 23, 32'hA3,       1, 12, 32'h12,  1, 13, 1, 23, 32'hA3,       3, 1, 32'h3C00));
    vt.push_back(mk(1, 24, 32'hA4,       1, 13, 32'h13,  0,  0, 1, 24, 32'hA4,       4, 0, 32'h3C00));
    vt.push_back(mk(1, 25, 32'hA5,       1, 14, 32'h14,  1, 14, 1, 25, 32'hA5,       4, 0, 32'h7C00));
    vt.push_back(mk(0,  0, 0,            1, 14, 32'h14,  0,  0, 1, 10, 32'h10,       3, 1, 32'h7C00));
    vt.push_back(mk(0,  0, 0,            1, 14, 32'h14,  0,  0, 1, 11, 32'h11,       3, 1, 32'h7800));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 1, 12, 32'h12,       2, 1, 32'h7000));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 1, 13, 32'h13,       1, 1, 32'h6000));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 1, 14, 32'h14,       0, 1, 32'h4000));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 0, 14, 32'h14,       0, 1, 32'h0));
    vt.push_back(mk(1,  3, 32'h33,       0,  0, 0,       1,  9, 1,  3, 32'h33,       0, 1, 32'h0200));
    vt.push_back(mk(1,  4, 32'h44,       1,  9, 32'h99,  0,  0, 1,  4, 32'h44,       1, 1, 32'h0200));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 1,  9, 32'h99,       0, 1, 32'h0200));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       1,  9, 0,  9, 32'h99,       0, 1, 32'h0200));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 0,  9, 32'h99,       0, 1, 32'h0200));
    vt.push_back(mk(1,  9, 32'h55,       0,  0, 0,       0,  0, 1,  9, 32'h55,       0, 1, 32'h0200));
    vt.push_back(mk(0,  0, 0,            0,  0, 0,       0,  0, 0,  9, 32'h55,       0, 1, 32'h0200));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we",      32'(bus.rf_we),      32'h0);
    chk("rst_rf_waddr",   32'(bus.rf_waddr),   32'h0);
    chk("rst_rf_wdata",   bus.rf_wdata,        32'h0);
    chk("rst_busy",       bus.busy,            32'h0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
    chk("rst_lu_ready",   32'(bus.lu_ready),   32'h1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) apply(vt[i], i);

    // Long-latency result for x7 with the pipe idle
    @(negedge clk);
    drive_idle();
    bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd7;
    tick_check();
    chk("ll_alloc_busy", bus.busy, 32'h0280);
    @(negedge clk);
    drive_idle();
    bus.lu_valid = 1'b1; bus.lu_rd = 5'd7; bus.lu_wdata = 32'h12345678;
    tick_check();
`ifdef WB_ARB_BYPASS_EN
    chk("ll_n1_rf_we",    32'(bus.rf_we),      32'h1);
    chk("ll_n1_rf_waddr", 32'(bus.rf_waddr),   32'h7);
    chk("ll_n1_rf_wdata", bus.rf_wdata,        32'h12345678);
    chk("ll_n1_count",    32'(bus.fifo_count), 32'h0);
    chk("ll_n1_busy",     bus.busy,            32'h0280);
    @(negedge clk);
    drive_idle();
    tick_check();
    chk("ll_n2_rf_we",    32'(bus.rf_we),      32'h0);
    chk("ll_n2_busy",     bus.busy,            32'h0200);
`else
    chk("ll_n1_rf_we",    32'(bus.rf_we),      32'h0);
    chk("ll_n1_count",    32'(bus.fifo_count), 32'h1);
    chk("ll_n1_busy",     bus.busy,            32'h0280);
    @(negedge clk);
    drive_idle();
    tick_check();
    chk("ll_n2_rf_we",    32'(bus.rf_we),      32'h1);
    chk("ll_n2_rf_waddr", 32'(bus.rf_waddr),   32'h7);
    chk("ll_n2_rf_wdata", bus.rf_wdata,        32'h12345678);
    chk("ll_n2_count",    32'(bus.fifo_count), 32'h0);
    chk("ll_n2_busy",     bus.busy,            32'h0280);
    tick_check();
    chk("ll_n3_rf_we",    32'(bus.rf_we),      32'h0);
    chk("ll_n3_busy",     bus.busy,            32'h0200);
`endif

    // Buffer three results behind a pipe stream, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.pipe_we = 1'b1; bus.pipe_rd = 5'(1 + i); bus.pipe_wdata = 32'(i);
      bus.alloc_valid = (i < 3); bus.alloc_rd = 5'(15 + i);
      bus.lu_valid = (i > 0); bus.lu_rd = 5'(14 + i); bus.lu_wdata = 32'(32'hC0 + i);
      tick_check();
    end
    chk("pre_rst_count", 32'(bus.fifo_count), 32'h3);
    chk("pre_rst_busy",  bus.busy,            32'h0003_8200);
    @(negedge clk);
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rf_we",    32'(bus.rf_we),      32'h0);
    chk("mid_rst_busy",     bus.busy,            32'h0);
    chk("mid_rst_count",    32'(bus.fifo_count), 32'h0);
    chk("mid_rst_lu_ready", 32'(bus.lu_ready),   32'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_check();
      chk($sformatf("post_rst%0d_rf_we", i), 32'(bus.rf_we),      32'h0);
      chk($sformatf("post_rst%0d_count", i), 32'(bus.fifo_count), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
